// File: rtl/dct8x8_arb.sv
// Block-granular two-channel arbiter and result router in front of the 8x8 DCT engine.
// Optional feature macro: DCT8X8_ARB_RR_EN (round-robin grant; fixed priority to channel 0 when undefined).
module dct8x8_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAG_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s0_vld_i,
  input  logic [DATA_WIDTH*16-1:0]       s0_data_i,
  output logic                           s0_rdy_o,
  input  logic                           s1_vld_i,
  input  logic [DATA_WIDTH*16-1:0]       s1_data_i,
  output logic                           s1_rdy_o,
  output logic                           dct_vld_o,
  output logic [DATA_WIDTH*16-1:0]       dct_data_o,
  input  logic                           dct_rdy_i,
  input  logic                           dct_vld_i,
  input  logic [(DATA_WIDTH+8)*16-1:0]   dct_data_i,
  output logic                           dct_rdy_o,
  output logic                           m0_vld_o,
  output logic [(DATA_WIDTH+8)*16-1:0]   m0_data_o,
  input  logic                           m0_rdy_i,
  output logic                           m1_vld_o,
  output logic [(DATA_WIDTH+8)*16-1:0]   m1_data_o,
  input  logic                           m1_rdy_i,
  output logic                           busy_o,
  output logic [$clog2(TAG_DEPTH):0]     inflight_o
);

  localparam int unsigned PW = $clog2(TAG_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic [1:0]     in_beat_q, in_beat_d;
  logic [1:0]     out_beat_q;
  logic           win_c;
  logic           grant_c;
  logic           in_hs_c;
  logic           out_hs_c;
  logic           pop_c;
  logic           full_c;
  logic           empty_c;
  logic           head_tag_c;
  logic [CW-1:0]  count_c;
  logic [CW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TAG_DEPTH-1:0] tag_mem_q;

  // Winner selection among requesting channels
`ifdef DCT8X8_ARB_RR_EN
  logic last_q;

  always_comb begin
    win_c = ~s0_vld_i;
    if (s0_vld_i && s1_vld_i) win_c = ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_q <= 1'b1;
    else if (grant_c) last_q <= win_c;
  end
`else
  always_comb begin
    win_c = ~s0_vld_i;
  end
`endif

  assign grant_c = (state_q == IDLE) && (s0_vld_i || s1_vld_i) && !full_c;
  assign in_hs_c = dct_vld_o && dct_rdy_i;

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      in_beat_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      in_beat_q <= in_beat_d;
    end
  end

  // Issue FSM next state
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    in_beat_d = in_beat_q;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          state_d   = BUSY;
          owner_d   = win_c;
          in_beat_d = 2'd0;
        end
      end
      BUSY: begin
        if (in_hs_c) begin
          in_beat_d = in_beat_q + 2'd1;
          if (in_beat_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM outputs: the owner is wired straight through to the engine
  always_comb begin
    s0_rdy_o   = 1'b0;
    s1_rdy_o   = 1'b0;
    dct_vld_o  = 1'b0;
    dct_data_o = owner_q ? s1_data_i : s0_data_i;
    if (state_q == BUSY) begin
      dct_vld_o = owner_q ? s1_vld_i : s0_vld_i;
      s0_rdy_o  = !owner_q && dct_rdy_i;
      s1_rdy_o  =  owner_q && dct_rdy_i;
    end
  end

  assign busy_o = (state_q == BUSY);

  // In-order tag FIFO recording the owner of every issued block
  assign count_c    = wr_ptr_q - rd_ptr_q;
  assign full_c     = (count_c == CW'(TAG_DEPTH));
  assign empty_c    = (count_c == CW'(0));
  assign head_tag_c = tag_mem_q[rd_ptr_q[PW-1:0]];
  assign inflight_o = count_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_mem_q <= '0;
    end else begin
      if (grant_c) begin
        tag_mem_q[wr_ptr_q[PW-1:0]] <= win_c;
        wr_ptr_q <= wr_ptr_q + CW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  // Return path steered by the head tag
  always_comb begin
    m0_vld_o  = 1'b0;
    m1_vld_o  = 1'b0;
    dct_rdy_o = 1'b0;
    if (!empty_c) begin
      m0_vld_o  = !head_tag_c && dct_vld_i;
      m1_vld_o  =  head_tag_c && dct_vld_i;
      dct_rdy_o = head_tag_c ? m1_rdy_i : m0_rdy_i;
    end
  end

  assign m0_data_o = dct_data_i;
  assign m1_data_o = dct_data_i;
  assign out_hs_c  = dct_vld_i && dct_rdy_o;
  assign pop_c     = out_hs_c && (out_beat_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_beat_q <= 2'd0;
    else if (out_hs_c) out_beat_q <= out_beat_q + 2'd1;
  end

endmodule

// File: tb/tb_dct8x8_arb.sv
// Scoreboard bench for dct8x8_arb: source/engine/sink models driven on negedge, checked 2 time units later.
module tb_dct8x8_arb;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = DW * 16;
  localparam int unsigned OW = (DW + 8) * 16;
  localparam int unsigned TD = 4;
  localparam int unsigned CW = $clog2(TD) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_vld_i, s1_vld_i, s0_rdy_o, s1_rdy_o;
  logic [IW-1:0] s0_data_i, s1_data_i, dct_data_o;
  logic          dct_vld_o, dct_rdy_i, dct_vld_i, dct_rdy_o;
  logic [OW-1:0] dct_data_i, m0_data_o, m1_data_o;
  logic          m0_vld_o, m1_vld_o, m0_rdy_i, m1_rdy_i, busy_o;
  logic [CW-1:0] inflight_o;

  always #5 clk = ~clk;

  dct8x8_arb #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_vld_i(s0_vld_i), .s0_data_i(s0_data_i), .s0_rdy_o(s0_rdy_o),
    .s1_vld_i(s1_vld_i), .s1_data_i(s1_data_i), .s1_rdy_o(s1_rdy_o),
    .dct_vld_o(dct_vld_o), .dct_data_o(dct_data_o), .dct_rdy_i(dct_rdy_i),
    .dct_vld_i(dct_vld_i), .dct_data_i(dct_data_i), .dct_rdy_o(dct_rdy_o),
    .m0_vld_o(m0_vld_o), .m0_data_o(m0_data_o), .m0_rdy_i(m0_rdy_i),
    .m1_vld_o(m1_vld_o), .m1_data_o(m1_data_o), .m1_rdy_i(m1_rdy_i),
    .busy_o(busy_o), .inflight_o(inflight_o)
  );

  logic [IW-1:0] src0_q[$], src1_q[$], iss_exp[$];
  logic [OW-1:0] eng_q[$], m0_exp[$], m1_exp[$];
  bit ret_en, rnd, m0_rdy_en, m1_rdy_en;
  bit acc0, acc1, eng_acc;
  int n_cmp = 0;
  int n_err = 0;
  int iss_cnt = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] beat_data(input int ch, input int blk, input int b);
    logic [7:0] tb;
    tb = 8'((ch << 4) | blk);
    return {{15{tb}}, 8'(b + 1)};
  endfunction

  // Engine model's transform; only has to be distinguishable from its input
  function automatic logic [OW-1:0] coef(input logic [IW-1:0] x);
    return OW'(x) ^ {16{16'hC300}};
  endfunction

  task automatic queue_block(input int ch, input int blk);
    for (int b = 0; b < 4; b++) begin
      if (ch == 0) begin
        src0_q.push_back(beat_data(ch, blk, b));
        m0_exp.push_back(coef(beat_data(ch, blk, b)));
      end else begin
        src1_q.push_back(beat_data(ch, blk, b));
        m1_exp.push_back(coef(beat_data(ch, blk, b)));
      end
    end
  endtask

  task automatic expect_issue(input int ch, input int blk);
    for (int b = 0; b < 4; b++) iss_exp.push_back(beat_data(ch, blk, b));
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic clear_queues();
    src0_q.delete(); src1_q.delete(); iss_exp.delete();
    eng_q.delete(); m0_exp.delete(); m1_exp.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_queues();
    ret_en = 0; rnd = 0; m0_rdy_en = 1; m1_rdy_en = 1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic bit pending();
    return (src0_q.size() + src1_q.size() + iss_exp.size() + m0_exp.size() + m1_exp.size()) != 0;
  endfunction

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while (pending() && t < limit) begin
      tick();
      t++;
    end
    chk(tag, OW'(pending()), OW'(0));
    tick();
  endtask

  // Source, engine and sink models; drive on negedge, observe after inputs settle
  always @(negedge clk) begin
    if (!rst_n) begin
      s0_vld_i = 0; s1_vld_i = 0; dct_vld_i = 0;
      acc0 = 0; acc1 = 0; eng_acc = 0;
    end else begin
      if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (eng_acc && eng_q.size() > 0) void'(eng_q.pop_front());
      s0_vld_i   = src0_q.size() > 0;
      s0_data_i  = s0_vld_i ? src0_q[0] : '0;
      s1_vld_i   = src1_q.size() > 0;
      s1_data_i  = s1_vld_i ? src1_q[0] : '0;
      dct_vld_i  = ret_en && (eng_q.size() > 0);
      dct_data_i = dct_vld_i ? eng_q[0] : '0;
      dct_rdy_i  = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      m0_rdy_i   = m0_rdy_en && (!rnd || 1'($urandom_range(1, 0)));
      m1_rdy_i   = m1_rdy_en && (!rnd || 1'($urandom_range(1, 0)));
      #2;
      if (rst_n) begin
        if (s0_rdy_o && s1_rdy_o) chk("rdy_both", OW'(1), OW'(0));
        if (m0_vld_o && m1_vld_o) chk("mvld_both", OW'(1), OW'(0));
        acc0    = s0_vld_i && s0_rdy_o;
        acc1    = s1_vld_i && s1_rdy_o;
        eng_acc = dct_vld_i && dct_rdy_o;
        if (dct_vld_o && dct_rdy_i) begin
          iss_cnt++;
          if (iss_exp.size() == 0) chk("iss_extra", OW'(1), OW'(0));
          else chk("iss_data", OW'(dct_data_o), OW'(iss_exp.pop_front()));
          eng_q.push_back(coef(dct_data_o));
        end
        if (m0_vld_o && m0_rdy_i) begin
          if (m0_exp.size() == 0) chk("m0_extra", OW'(1), OW'(0));
          else chk("m0_data", m0_data_o, m0_exp.pop_front());
        end
        if (m1_vld_o && m1_rdy_i) begin
          if (m1_exp.size() == 0) chk("m1_extra", OW'(1), OW'(0));
          else chk("m1_data", m1_data_o, m1_exp.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base;
    rst_n = 1'b0;
    s0_vld_i = 0; s1_vld_i = 0; s0_data_i = '0; s1_data_i = '0;
    dct_vld_i = 0; dct_data_i = '0; dct_rdy_i = 1; m0_rdy_i = 1; m1_rdy_i = 1;
    ret_en = 0; rnd = 0; m0_rdy_en = 1; m1_rdy_en = 1;

    // Reset values with both sources requesting
    #12;
    s0_vld_i = 1; s1_vld_i = 1; dct_vld_i = 1;
    #1;
    chk("rst_s0_rdy", OW'(s0_rdy_o), OW'(0));
    chk("rst_s1_rdy", OW'(s1_rdy_o), OW'(0));
    chk("rst_dct_vld", OW'(dct_vld_o), OW'(0));
    chk("rst_dct_rdy", OW'(dct_rdy_o), OW'(0));
    chk("rst_m_vld", OW'({m0_vld_o, m1_vld_o}), OW'(0));
    chk("rst_busy", OW'(busy_o), OW'(0));
    chk("rst_inflight", OW'(inflight_o), OW'(0));
    do_reset();

    // Single block on channel 0: 1-cycle grant, in-order beats, return only to m0
    queue_block(0, 0); expect_issue(0, 0);
    tick();
    chk("t1_idle_busy", OW'(busy_o), OW'(0));
    chk("t1_idle_rdy", OW'(s0_rdy_o), OW'(0));
    tick();
    chk("t1_grant_busy", OW'(busy_o), OW'(1));
    chk("t1_grant_rdy", OW'(s0_rdy_o), OW'(1));
    chk("t1_inflight1", OW'(inflight_o), OW'(1));
    tick(); tick(); tick(); tick();
    chk("t1_done_busy", OW'(busy_o), OW'(0));
    chk("t1_done_iss", OW'(iss_exp.size()), OW'(0));
    chk("t1_inflight_hold", OW'(inflight_o), OW'(1));
    ret_en = 1;
    wait_idle("t1_drain", 50);
    chk("t1_inflight0", OW'(inflight_o), OW'(0));

    // Both channels always valid, random backpressure on both sides
    do_reset();
    for (int b = 0; b < 4; b++) begin
      queue_block(0, b);
      queue_block(1, b);
    end
`ifdef DCT8X8_ARB_RR_EN
    for (int b = 0; b < 4; b++) begin
      expect_issue(0, b);
      expect_issue(1, b);
    end
`else
    for (int b = 0; b < 4; b++) expect_issue(0, b);
    for (int b = 0; b < 4; b++) expect_issue(1, b);
`endif
    rnd = 1; ret_en = 1;
    wait_idle("t2_drain", 600);
    rnd = 0;
    tick();
    chk("t2_inflight0", OW'(inflight_o), OW'(0));

    // Tag FIFO full, then regrant right after one block returns
    do_reset();
    for (int b = 0; b < 5; b++) begin
      queue_block(0, b);
      expect_issue(0, b);
    end
    for (int i = 0; i < 30; i++) tick();
    chk("t3_full_busy", OW'(busy_o), OW'(0));
    chk("t3_full_rdy", OW'({s0_rdy_o, s1_rdy_o}), OW'(0));
    chk("t3_full_inflight", OW'(inflight_o), OW'(4));
    chk("t3_full_iss_left", OW'(iss_exp.size()), OW'(4));
    ret_en = 1;
    t = 0;
    while (inflight_o != CW'(3) && t < 30) begin
      tick();
      t++;
    end
    chk("t3_pop", OW'(inflight_o), OW'(3));
    chk("t3_pop_busy", OW'(busy_o), OW'(0));
    tick();
    chk("t3_regrant_busy", OW'(busy_o), OW'(1));
    chk("t3_regrant_inflight", OW'(inflight_o), OW'(4));
    wait_idle("t3_drain", 200);

    // Return backpressure with head tag 1
    do_reset();
    m1_rdy_en = 0;
    queue_block(1, 0); expect_issue(1, 0);
    ret_en = 1;
    t = 0;
    while (!dct_vld_i && t < 20) begin
      tick();
      t++;
    end
    chk("t4_ret_vld", OW'(dct_vld_i), OW'(1));
    chk("t4_dct_rdy", OW'(dct_rdy_o), OW'(0));
    chk("t4_m0_vld", OW'(m0_vld_o), OW'(0));
    chk("t4_m1_vld", OW'(m1_vld_o), OW'(1));
    tick(); tick(); tick();
    chk("t4_stalled", OW'(m1_exp.size()), OW'(4));
    m1_rdy_en = 1;
    wait_idle("t4_drain", 50);
    chk("t4_inflight0", OW'(inflight_o), OW'(0));

    // Grant in the same cycle as the last return beat of the previous block
    do_reset();
    queue_block(0, 0); expect_issue(0, 0);
    t = 0;
    while (iss_exp.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    tick(); tick();
    chk("t5_setup_inflight", OW'(inflight_o), OW'(1));
    ret_en = 1;
    tick(); tick(); tick();
    queue_block(1, 0); expect_issue(1, 0);
    tick();
    chk("t5_pre_inflight", OW'(inflight_o), OW'(1));
    chk("t5_pre_busy", OW'(busy_o), OW'(0));
    tick();
    chk("t5_post_inflight", OW'(inflight_o), OW'(1));
    chk("t5_post_busy", OW'(busy_o), OW'(1));
    wait_idle("t5_drain", 50);
    chk("t5_inflight0", OW'(inflight_o), OW'(0));

    // Reset in the middle of an issued block
    do_reset();
    queue_block(0, 0); expect_issue(0, 0);
    base = iss_cnt;
    t = 0;
    while (iss_cnt < base + 2 && t < 20) begin
      tick();
      t++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_rdy", OW'({s0_rdy_o, s1_rdy_o}), OW'(0));
    chk("t6_rst_dct_vld", OW'(dct_vld_o), OW'(0));
    chk("t6_rst_dct_rdy", OW'(dct_rdy_o), OW'(0));
    chk("t6_rst_m_vld", OW'({m0_vld_o, m1_vld_o}), OW'(0));
    chk("t6_rst_busy", OW'(busy_o), OW'(0));
    chk("t6_rst_inflight", OW'(inflight_o), OW'(0));
    clear_queues();
    tick(); tick();
    rst_n = 1'b1;
    queue_block(1, 0); expect_issue(1, 0);
    t = 0;
    while (iss_exp.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    tick();
    chk("t6_new_iss", OW'(iss_exp.size()), OW'(0));
    chk("t6_new_inflight", OW'(inflight_o), OW'(1));
    ret_en = 1;
    wait_idle("t6_drain", 50);
    chk("t6_inflight0", OW'(inflight_o), OW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dct8x8_arb.md
# dct8x8_arb

Block-granular two-channel arbiter and result router for the 2-D 8x8 DCT pipeline (`dct8x8_top`). It lets two pixel sources share one DCT engine, for example luma and chroma. Each grant covers one whole 8x8 block: 4 beats of 2 rows × 8 pixels. The arbiter records the owner of every issued block in an in-order tag FIFO. It uses that tag to steer the 4 returning coefficient beats back to the matching channel.

## Interface
Parameters:
- DATA_WIDTH, 8, input pixel width; coefficient width is DATA_WIDTH+8
- TAG_DEPTH, 4, maximum blocks in flight inside the DCT engine; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s0_vld_i / s1_vld_i  in  1  source valid, channel 0/1
- s0_data_i / s1_data_i  in  DATA_WIDTH*16  two pixel rows per beat
- s0_rdy_o / s1_rdy_o  out  1  source ready
- dct_vld_o  out  1  valid to DCT engine input
- dct_data_o  out  DATA_WIDTH*16  data to DCT engine
- dct_rdy_i  in  1  DCT engine input ready
- dct_vld_i  in  1  DCT engine output valid
- dct_data_i  in  (DATA_WIDTH+8)*16  coefficient beat from DCT engine
- dct_rdy_o  out  1  ready to DCT engine output
- m0_vld_o / m1_vld_o  out  1  result valid, channel 0/1
- m0_data_o / m1_data_o  out  (DATA_WIDTH+8)*16  coefficients, fanned out to both channels
- m0_rdy_i / m1_rdy_i  in  1  result ready
- busy_o  out  1  input FSM in BUSY
- inflight_o  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy

## Operation
- Issue FSM, states IDLE and BUSY; registers `owner` (1 bit) and `in_beat` (2 bits).
- IDLE:
  - s0_rdy_o = s1_rdy_o = 0 and dct_vld_o = 0.
  - If any s*_vld_i = 1 and the tag FIFO is not full, select a winner.
  - Then go to BUSY, set owner to the winner, clear in_beat and push the owner onto the tag FIFO.
- BUSY:
  - dct_vld_o = s[owner]_vld_i, dct_data_o = s[owner]_data_i and s[owner]_rdy_o = dct_rdy_i; the other channel's ready is 0.
  - in_beat increments on each dct_vld_o && dct_rdy_i.
  - A handshake with in_beat = 3 returns the FSM to IDLE.
- Selection: round-robin via `last` register (reset 1, so channel 0 wins first); the channel not granted last wins when both are valid; a lone requester always wins.
- Return path:
  - With the tag FIFO empty: dct_rdy_o = 0 and m*_vld_o = 0.
  - Otherwise, with head tag t: m[t]_vld_o = dct_vld_i, the other m*_vld_o = 0, and dct_rdy_o = m[t]_rdy_i.
  - `out_beat` (2 bits) increments on each dct_vld_i && dct_rdy_o; the handshake at out_beat = 3 pops the tag.
- Tag FIFO: push and pop in the same cycle is legal; occupancy is unchanged. Push never occurs when full, because IDLE does not grant while full.
- DCT engine and arbiter share rst_n; a reset mid-block discards all partial blocks and all tags.

## Timing
- Reset values:
  - outputs: s*_rdy_o 0, dct_vld_o 0, dct_rdy_o 0, m*_vld_o 0, busy_o 0, inflight_o 0
  - state: FSM IDLE, in_beat 0, out_beat 0, last 1
- Grant latency: 1 cycle. A valid seen in IDLE at edge N puts the FSM in BUSY from N+1, and the first beat can transfer in cycle N+1.
- Issue throughput: 4 beats per 5 cycles per block; the IDLE cycle between blocks is mandatory.
- Data and handshake paths in BUSY and on the return side are combinational: zero added latency, no added storage.
- inflight_o reflects pushes and pops registered at the clock edge.
- A source must hold vld/data until accepted. A block must be 4 consecutive beats from one source; sources do not interleave mid-block.

## Configuration
- DCT8X8_ARB_RR_EN defined: round-robin selection as in Operation.
- DCT8X8_ARB_RR_EN undefined: fixed priority; channel 0 wins whenever s0_vld_i = 1. The `last` register is removed.

## Test plan
- Single block, channel 0:
  - Stimulus: s0 sends beats 0x…01–0x…04; return beats driven on dct_*_i.
  - Grant is 1 cycle after vld; dct_data_o carries the 4 beats in order; inflight_o = 1.
  - The 4 return beats appear only on m0; inflight_o = 0 after the 4th.
- Both channels always valid, RR build: grant order 0,1,0,1; without DCT8X8_ARB_RR_EN the order is 0,0,0,0.
- Full FIFO:
  - TAG_DEPTH = 4 with dct_vld_i held 0: after 4 blocks, busy_o = 0, both s*_rdy_o = 0 and inflight_o = 4.
  - Completing one returned block regrants within 1 cycle.
- Return backpressure:
  - Head tag 1 with m1_rdy_i = 0: dct_rdy_o = 0 and m0_vld_o = 0 while dct_vld_i = 1.
  - Raising m1_rdy_i drains 4 beats to m1.
- Simultaneous push/pop: a grant in the same cycle as the 4th return handshake leaves inflight_o unchanged, and tag order is preserved.
- Reset mid-block:
  - rst_n low after 2 issued beats: all outputs take reset values asynchronously.
  - After release, a new s1 block issues from beat 0 with inflight_o = 1.
